// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator/demodulator pair: default counter
// width and the demodulator's measurement state encoding.
package pwm_pkg;

  localparam int PWM_COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    SEEK = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/pwm_demodulator_sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous input, plus a delayed copy of the
// synchronised level for single-cycle rise/fall detection.
module sync_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      // NOTE: non-blocking so each flop takes its predecessor's pre-edge value;
      // blocking assignments here would collapse the chain into a single stage.
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_prev;
  assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/pwm_demodulator.sv
// Measures high time and rise-to-rise period of an asynchronous PWM input in
// clock cycles, and flags a lost/stuck line after a programmable timeout.
module pwm_demodulator
  import pwm_pkg::*;
#(
  parameter int COUNT_WIDTH = PWM_COUNT_WIDTH,
  parameter int TIMEOUT     = 50000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   pwm_in,
  output logic [COUNT_WIDTH-1:0] high_width,
  output logic [COUNT_WIDTH-1:0] period,
  output logic                   valid,
  output logic                   signal_lost,
  output logic                   stuck_level
);

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE     = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX     = '1;
  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_CNT = COUNT_WIDTH'(TIMEOUT);

  logic w_level;
  logic w_rise;
  logic w_fall;
  logic w_edge;
  logic w_timeout;

  pwm_state_e             r_state,      w_state_nxt;
  logic [COUNT_WIDTH-1:0] r_cnt,        w_cnt_nxt;
  logic [COUNT_WIDTH-1:0] r_h_latch,    w_h_latch_nxt;
  logic [COUNT_WIDTH-1:0] r_high_width, w_high_width_nxt;
  logic [COUNT_WIDTH-1:0] r_period,     w_period_nxt;
  logic                   r_valid,      w_valid_nxt;
  logic                   r_lost,       w_lost_nxt;
  logic                   r_stuck,      w_stuck_nxt;

  sync_edge_detect u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (pwm_in),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_edge = w_rise | w_fall;
  // >= rather than == so a fall landing exactly on TIMEOUT cannot let the
  // counter slip past the threshold and never time out.
  assign w_timeout = ~w_edge & (r_cnt >= TIMEOUT_CNT);

  always_comb begin
    // NOTE: every next-state value gets a default first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    w_state_nxt      = r_state;
    w_cnt_nxt        = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;
    w_h_latch_nxt    = r_h_latch;
    w_high_width_nxt = r_high_width;
    w_period_nxt     = r_period;
    w_valid_nxt      = 1'b0;
    w_lost_nxt       = r_lost;
    w_stuck_nxt      = r_stuck;

    if (w_rise) begin
      w_cnt_nxt = CNT_ONE;
    end else if (w_timeout) begin
      w_cnt_nxt = TIMEOUT_CNT;
    end

    if (w_timeout) begin
      w_state_nxt = SEEK;
      w_lost_nxt  = 1'b1;
      w_stuck_nxt = w_level;
    end else begin
      case (r_state)
        SEEK: begin
          if (w_rise) w_state_nxt = HIGH;
        end
        HIGH: begin
          if (w_fall) begin
            w_state_nxt   = LOW;
            w_h_latch_nxt = r_cnt;
          end
        end
        LOW: begin
          if (w_rise) begin
            w_state_nxt      = HIGH;
            w_period_nxt     = r_cnt;
            w_high_width_nxt = r_h_latch;
            w_valid_nxt      = 1'b1;
            w_lost_nxt       = 1'b0;
          end
        end
        default: w_state_nxt = SEEK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= SEEK;
      r_cnt        <= '0;
      r_h_latch    <= '0;
      r_high_width <= '0;
      r_period     <= '0;
      r_valid      <= 1'b0;
      r_lost       <= 1'b0;
      r_stuck      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_h_latch    <= w_h_latch_nxt;
      r_high_width <= w_high_width_nxt;
      r_period     <= w_period_nxt;
      r_valid      <= w_valid_nxt;
      r_lost       <= w_lost_nxt;
      r_stuck      <= w_stuck_nxt;
    end
  end

  assign high_width  = r_high_width;
  assign period      = r_period;
  assign valid       = r_valid;
  assign signal_lost = r_lost;
  assign stuck_level = r_stuck;

endmodule
